// File: rtl/uart_line_rx.sv
// UART receiver with a line assembler. Frames are deserialised with optional
// parity, and good characters are packed into a line that is handed off on CR/LF.
module uart_line_rx #(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int LINE_CHARS = 4
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                rx,
   output logic                                byte_valid,
   output logic [DATA_BITS-1:0]                byte_data,
   output logic                                frame_err,
   output logic                                parity_err,
   output logic                                line_valid,
   output logic [DATA_BITS*LINE_CHARS-1:0]     line_data,
   output logic [$clog2(LINE_CHARS+1)-1:0]     line_len,
   output logic                                line_trunc,
   input  logic                                line_ack,
   output logic                                line_overrun
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int BIT_W        = $clog2(DATA_BITS + 1);
   localparam int LEN_W        = $clog2(LINE_CHARS + 1);
   localparam int BUF_W        = DATA_BITS * LINE_CHARS;

   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]     CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]     BIT_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [LEN_W-1:0]     LEN_FULL = LEN_W'(LINE_CHARS);
   localparam logic [DATA_BITS-1:0] CHAR_LF  = DATA_BITS'(10);
   localparam logic [DATA_BITS-1:0] CHAR_CR  = DATA_BITS'(13);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   state_t               state;
   logic                 rx_s1;
   logic                 rx_s2;
   logic                 rx_prev;
   logic [1:0]           sync_warm;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bitcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad;

   logic [BUF_W-1:0]     line_buf;
   logic [LEN_W-1:0]     count;
   logic                 trunc;
   logic                 is_term;
   logic                 pending;

   // rx_prev only reports a genuine high once the synchroniser has flushed its
   // reset value, so a line held low through reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b0;
         sync_warm  <= 2'b00;
         state      <= S_IDLE;
         cnt        <= '0;
         bitcnt     <= '0;
         shreg      <= '0;
         par_bad    <= 1'b0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         rx_s1      <= rx;
         rx_s2      <= rx_s1;
         sync_warm  <= {sync_warm[0], 1'b1};
         rx_prev    <= rx_s2 & sync_warm[1];
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  state <= S_START;
                  cnt   <= '0;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt     <= '0;
                  bitcnt  <= '0;
                  par_bad <= 1'b0;
                  state   <= rx_s2 ? S_IDLE : S_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  shreg  <= {rx_s2, shreg[DATA_BITS-1:1]};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == BIT_LAST)
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_PARITY: begin
               if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  par_bad <= (PARITY == 1) ? ~(^shreg ^ rx_s2) : (^shreg ^ rx_s2);
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (!rx_s2) begin
                     frame_err <= 1'b1;
                     state     <= S_BREAK;
                  end else if (par_bad) begin
                     parity_err <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     byte_valid <= 1'b1;
                     byte_data  <= shreg;
                     state      <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_BREAK: begin
               if (rx_s2)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // An ack arriving with a terminator counts first, so the pending slot is free.
   always_comb begin
      is_term = (byte_data == CHAR_LF) || (byte_data == CHAR_CR);
      pending = line_valid && !line_ack;
   end

   // The line assembler works off the registered byte_valid pulse, which puts
   // the line handoff one cycle behind the terminator's byte_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_valid   <= 1'b0;
         line_data    <= '0;
         line_len     <= '0;
         line_trunc   <= 1'b0;
         line_overrun <= 1'b0;
         line_buf     <= '0;
         count        <= '0;
         trunc        <= 1'b0;
      end else begin
         line_overrun <= 1'b0;
         if (line_valid && line_ack)
            line_valid <= 1'b0;
         if (byte_valid) begin
            if (!is_term) begin
               line_buf <= (line_buf << DATA_BITS) | BUF_W'(byte_data);
               if (count == LEN_FULL)
                  trunc <= 1'b1;
               else
                  count <= count + 1'b1;
            end else if (count != '0) begin
               line_buf <= '0;
               count    <= '0;
               trunc    <= 1'b0;
               if (pending) begin
                  line_overrun <= 1'b1;
               end else begin
                  line_valid <= 1'b1;
                  line_data  <= line_buf;
                  line_len   <= count;
                  line_trunc <= trunc;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_line_rx.sv
// Self-checking bench for uart_line_rx: 8N1 and 8E1 instances at 16 clocks per bit,
// table vectors, directed corner cases and a random run against a line model.
module tb_uart_line_rx;

   localparam int CLK_HZ     = 1843200;
   localparam int BAUD       = 115200;
   localparam int DATA_BITS  = 8;
   localparam int LINE_CHARS = 4;
   localparam int CPB        = CLK_HZ / BAUD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        rxP = 1'b1;
   logic        line_ack = 1'b0;
   logic        lineAckP = 1'b0;

   logic        byte_valid, frame_err, parity_err, line_valid, line_trunc, line_overrun;
   logic [7:0]  byte_data;
   logic [31:0] line_data;
   logic [2:0]  line_len;

   logic        byteValidP, frameErrP, parityErrP, lineValidP, lineTruncP, lineOverrunP;
   logic [7:0]  byteDataP;
   logic [31:0] lineDataP;
   logic [2:0]  lineLenP;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  len;
      logic        trunc;
   } line_t;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      logic       expByte;
      logic [7:0] expData;
      logic       expFrame;
   } vec_t;

   int          assertCount = 0;
   int          failCount = 0;

   logic [7:0]  byteQ[$];
   logic [7:0]  byteQP[$];
   line_t       lineQ[$];
   line_t       capLine;
   int          frameErrCnt = 0;
   int          parityErrCnt = 0;
   int          overrunCnt = 0;
   logic        lineValidPrev = 1'b0;

   logic [7:0]  modelBuf[$];
   bit          modelTrunc = 1'b0;
   line_t       expLines[$];
   bit          autoAck = 1'b0;

   always #5 clk = ~clk;

   uart_line_rx #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .PARITY(0), .LINE_CHARS(LINE_CHARS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .frame_err(frame_err), .parity_err(parity_err),
      .line_valid(line_valid), .line_data(line_data), .line_len(line_len),
      .line_trunc(line_trunc), .line_ack(line_ack), .line_overrun(line_overrun)
   );

   uart_line_rx #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DATA_BITS), .PARITY(2), .LINE_CHARS(LINE_CHARS)
   ) dut_p (
      .clk(clk), .rst_n(rst_n), .rx(rxP),
      .byte_valid(byteValidP), .byte_data(byteDataP),
      .frame_err(frameErrP), .parity_err(parityErrP),
      .line_valid(lineValidP), .line_data(lineDataP), .line_len(lineLenP),
      .line_trunc(lineTruncP), .line_ack(lineAckP), .line_overrun(lineOverrunP)
   );

   // Event recorder: samples both instances mid-cycle and logs every pulse.
   always @(negedge clk) begin
      if (byte_valid) byteQ.push_back(byte_data);
      if (frame_err) frameErrCnt++;
      if (line_overrun) overrunCnt++;
      if (line_valid && !lineValidPrev) begin
         capLine.data  = line_data;
         capLine.len   = line_len;
         capLine.trunc = line_trunc;
         lineQ.push_back(capLine);
      end
      lineValidPrev = line_valid;
      if (byteValidP) byteQP.push_back(byteDataP);
      if (parityErrP) parityErrCnt++;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drives n serial bits LSB first, one bit time each, then returns the line to idle.
   task automatic applyStimulus(input logic [15:0] bits, input int n, input bit toP);
      for (int i = 0; i < n; i++) begin
         if (toP) rxP = bits[i];
         else rx = bits[i];
         repeat (CPB) @(negedge clk);
      end
      if (toP) rxP = 1'b1;
      else rx = 1'b1;
   endtask

   // Reference line model: a queue of characters, oldest dropped past LINE_CHARS.
   task automatic modelChar(input logic [7:0] ch);
      line_t l;
      if (ch == 8'h0A || ch == 8'h0D) begin
         if (modelBuf.size() > 0) begin
            l.data = 32'h0;
            foreach (modelBuf[i]) l.data = (l.data << 8) | 32'(modelBuf[i]);
            l.len   = 3'(modelBuf.size());
            l.trunc = modelTrunc;
            expLines.push_back(l);
            modelBuf.delete();
            modelTrunc = 1'b0;
         end
      end else begin
         modelBuf.push_back(ch);
         if (modelBuf.size() > LINE_CHARS) begin
            void'(modelBuf.pop_front());
            modelTrunc = 1'b1;
         end
      end
   endtask

   task automatic sendChar(input logic [7:0] ch);
      applyStimulus({6'b0, 1'b1, ch, 1'b0}, 10, 1'b0);
      modelChar(ch);
      if (autoAck && line_valid) begin
         line_ack = 1'b1;
         @(negedge clk);
         line_ack = 1'b0;
      end
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      modelBuf.delete();
      modelTrunc = 1'b0;
      repeat (2 * CPB) @(negedge clk);
   endtask

   initial begin
      vec_t        vecs[7];
      int          baseB, baseF, baseL, baseO, baseP, basePE, baseE, nExp;
      logic [7:0]  lastGood;
      logic [7:0]  sent[$];
      logic [7:0]  ch;
      bit          found;

      vecs[0] = '{8'h41, 1'b1, 1'b1, 8'h41, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
      vecs[3] = '{8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[4] = '{8'h55, 1'b1, 1'b1, 8'h55, 1'b0};
      vecs[5] = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[6] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};

      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", {byte_valid, byte_data, frame_err, parity_err, line_valid,
                                    line_trunc, line_overrun, line_len}, 64'h0);
      checkOutput("reset_line_data", line_data, 64'h0);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);

      // Table of single frames, some with a low stop bit.
      lastGood = 8'h00;
      for (int i = 0; i < 7; i++) begin
         baseB = byteQ.size();
         baseF = frameErrCnt;
         applyStimulus({6'b0, vecs[i].stopBit, vecs[i].data, 1'b0}, 10, 1'b0);
         repeat (2 * CPB) @(negedge clk);
         checkOutput($sformatf("vec%0d_bytes", i), byteQ.size() - baseB, vecs[i].expByte);
         if (vecs[i].expByte) begin
            checkOutput($sformatf("vec%0d_data", i), byteQ[$], vecs[i].expData);
            lastGood = vecs[i].expData;
         end
         checkOutput($sformatf("vec%0d_frame_err", i), frameErrCnt - baseF, vecs[i].expFrame);
         checkOutput($sformatf("vec%0d_byte_hold", i), byte_data, lastGood);
      end

      doReset();
      baseB = byteQ.size();
      sendChar(8'h41); sendChar(8'h42); sendChar(8'h0A);
      checkOutput("ab_bytes", byteQ.size() - baseB, 3);
      checkOutput("ab_byte0", byteQ[baseB], 8'h41);
      checkOutput("ab_byte1", byteQ[baseB + 1], 8'h42);
      checkOutput("ab_byte2", byteQ[baseB + 2], 8'h0A);
      checkOutput("ab_line_valid", line_valid, 1);
      checkOutput("ab_line_data", line_data, 32'h00004142);
      checkOutput("ab_line_len", line_len, 2);
      checkOutput("ab_line_trunc", line_trunc, 0);
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;
      checkOutput("ab_ack_clears", line_valid, 0);

      baseL = lineQ.size();
      baseO = overrunCnt;
      sendChar(8'h48); sendChar(8'h45); sendChar(8'h4C); sendChar(8'h4C);
      sendChar(8'h4F); sendChar(8'h0D); sendChar(8'h0A);
      repeat (CPB) @(negedge clk);
      checkOutput("hello_lines", lineQ.size() - baseL, 1);
      checkOutput("hello_data", line_data, 32'h454C4C4F);
      checkOutput("hello_len", line_len, 4);
      checkOutput("hello_trunc", line_trunc, 1);
      checkOutput("hello_no_overrun", overrunCnt - baseO, 0);
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;

      // Even parity: 0x41 has two ones, so the correct parity bit is 0.
      baseP = byteQP.size();
      basePE = parityErrCnt;
      applyStimulus({5'b0, 1'b1, 1'b1, 8'h41, 1'b0}, 11, 1'b1);
      repeat (CPB) @(negedge clk);
      checkOutput("par_bad_err", parityErrCnt - basePE, 1);
      checkOutput("par_bad_nobyte", byteQP.size() - baseP, 0);
      applyStimulus({5'b0, 1'b1, 1'b0, 8'h41, 1'b0}, 11, 1'b1);
      repeat (CPB) @(negedge clk);
      checkOutput("par_good_byte", byteQP.size() - baseP, 1);
      checkOutput("par_good_data", byteQP[$], 8'h41);
      checkOutput("par_good_noerr", parityErrCnt - basePE, 1);

      // Framing error followed by a long break.
      baseB = byteQ.size();
      baseF = frameErrCnt;
      applyStimulus({6'b0, 1'b0, 8'h33, 1'b0}, 10, 1'b0);
      rx = 1'b0;
      repeat (40 * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      checkOutput("break_frame_err", frameErrCnt - baseF, 1);
      checkOutput("break_nobyte", byteQ.size() - baseB, 0);
      sendChar(8'h55);
      checkOutput("break_recover_count", byteQ.size() - baseB, 1);
      checkOutput("break_recover_data", byteQ[$], 8'h55);

      // Short low glitch on an idle line.
      baseB = byteQ.size();
      baseF = frameErrCnt;
      rx = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      checkOutput("glitch_nobyte", byteQ.size() - baseB, 0);
      checkOutput("glitch_noframe", frameErrCnt - baseF, 0);
      sendChar(8'h5A);
      checkOutput("glitch_recover", byteQ[$], 8'h5A);

      // Overrun, then an ack landing with the terminator.
      doReset();
      baseO = overrunCnt;
      sendChar(8'h41); sendChar(8'h0A);
      sendChar(8'h42); sendChar(8'h0A);
      repeat (CPB) @(negedge clk);
      checkOutput("ovr_pulse", overrunCnt - baseO, 1);
      checkOutput("ovr_line_valid", line_valid, 1);
      checkOutput("ovr_line_data", line_data, 32'h41);
      checkOutput("ovr_line_len", line_len, 1);
      sendChar(8'h42);
      found = 1'b0;
      fork
         applyStimulus({6'b0, 1'b1, 8'h0A, 1'b0}, 10, 1'b0);
         begin
            for (int c = 0; c < 12 * CPB && !found; c++) begin
               @(negedge clk);
               if (byte_valid) begin
                  found = 1'b1;
                  line_ack = 1'b1;
                  @(negedge clk);
                  line_ack = 1'b0;
               end
            end
         end
      join
      repeat (CPB) @(negedge clk);
      checkOutput("sameack_seen", found, 1);
      checkOutput("sameack_no_overrun", overrunCnt - baseO, 1);
      checkOutput("sameack_valid", line_valid, 1);
      checkOutput("sameack_data", line_data, 32'h42);

      // Reset mid-frame with rx held low through and after reset.
      sendChar(8'h43);
      rx = 1'b0;
      repeat (CPB + CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_outputs", {byte_valid, byte_data, frame_err, parity_err, line_valid,
                                     line_trunc, line_overrun, line_len}, 64'h0);
      checkOutput("midrst_line_data", line_data, 64'h0);
      repeat (3) @(negedge clk);
      baseB = byteQ.size();
      baseF = frameErrCnt;
      rst_n = 1'b1;
      modelBuf.delete();
      modelTrunc = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      checkOutput("lowrst_nobyte", byteQ.size() - baseB, 0);
      checkOutput("lowrst_noframe", frameErrCnt - baseF, 0);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      sendChar(8'h44); sendChar(8'h0A);
      checkOutput("midrst_line_data_after", line_data, 32'h44);
      checkOutput("midrst_line_len_after", line_len, 1);
      line_ack = 1'b1;
      @(negedge clk);
      line_ack = 1'b0;

      // Random characters against the line model, acking every line.
      doReset();
      autoAck = 1'b1;
      baseB = byteQ.size();
      baseL = lineQ.size();
      baseE = expLines.size();
      baseO = overrunCnt;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 9))
            0: ch = 8'h0A;
            1: ch = 8'h0D;
            default: ch = 8'(8'h41 + $urandom_range(0, 25));
         endcase
         sent.push_back(ch);
         sendChar(ch);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      autoAck = 1'b0;
      repeat (CPB) @(negedge clk);
      checkOutput("rand_byte_count", byteQ.size() - baseB, sent.size());
      foreach (sent[i]) checkOutput($sformatf("rand_byte%0d", i), byteQ[baseB + i], sent[i]);
      nExp = expLines.size() - baseE;
      checkOutput("rand_line_count", lineQ.size() - baseL, nExp);
      for (int i = 0; i < nExp; i++) begin
         checkOutput($sformatf("rand_line%0d", i),
                     {lineQ[baseL + i].trunc, lineQ[baseL + i].len, lineQ[baseL + i].data},
                     {expLines[baseE + i].trunc, expLines[baseE + i].len, expLines[baseE + i].data});
      end
      checkOutput("rand_no_overrun", overrunCnt - baseO, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
